// File: rtl/arbiter_wrr_if.sv
// Arbiter request/grant bundle shared by requesters and the arbiter.
// master drives requests, acks and weights; slave is the arbiter.
interface arbiter_wrr_if #(
    parameter int PORTS        = 4,
    parameter int WEIGHT_WIDTH = 4
);
    localparam int EW = (PORTS > 1) ? $clog2(PORTS) : 1;

    logic [PORTS-1:0]              request;
    logic [PORTS-1:0]              acknowledge;
    logic [PORTS*WEIGHT_WIDTH-1:0] weight;
    logic [PORTS-1:0]              grant;
    logic                          grant_valid;
    logic [EW-1:0]                 grant_encoded;
    logic [WEIGHT_WIDTH-1:0]       credit;

    modport master (
        output request,
        output acknowledge,
        output weight,
        input  grant,
        input  grant_valid,
        input  grant_encoded,
        input  credit
    );

    modport slave (
        input  request,
        input  acknowledge,
        input  weight,
        output grant,
        output grant_valid,
        output grant_encoded,
        output credit
    );
endinterface

// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter: a port keeps the grant for up to
// weight acknowledged transfers, then the grant rotates.
module arbiter_wrr #(
    parameter int PORTS                 = 4,
    parameter int WEIGHT_WIDTH          = 4,
    parameter int ARB_LSB_HIGH_PRIORITY = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    arbiter_wrr_if.slave  bus
);
    localparam int EW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam logic [EW-1:0] LAST_RST =
        (ARB_LSB_HIGH_PRIORITY != 0) ? EW'(PORTS - 1) : '0;
    localparam logic [WEIGHT_WIDTH-1:0] ONE = WEIGHT_WIDTH'(1);
    localparam logic [PORTS-1:0] GBIT = PORTS'(1);

    logic [PORTS-1:0]        r_grant;
    logic [EW-1:0]           r_enc;
    logic                    r_valid;
    logic [WEIGHT_WIDTH-1:0] r_credit;
    logic [EW-1:0]           r_last;

    logic [PORTS-1:0]        w_grant;
    logic [EW-1:0]           w_enc;
    logic                    w_valid;
    logic [WEIGHT_WIDTH-1:0] w_credit;
    logic [EW-1:0]           w_last;

    logic                    w_found;
    logic [EW-1:0]           w_pick;
    logic [EW-1:0]           w_idx;
    logic [WEIGHT_WIDTH-1:0] w_wsel;
    logic [WEIGHT_WIDTH-1:0] w_wnew;
    logic                    w_cur_req;
    logic                    w_cur_ack;
    logic                    w_release;

    // Walk away from the last grant so it is the final candidate.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 1; i <= PORTS; i++) begin
            if (ARB_LSB_HIGH_PRIORITY != 0)
                w_idx = EW'((int'(r_last) + i) % PORTS);
            else
                w_idx = EW'((int'(r_last) - i + PORTS) % PORTS);
            if (!w_found && bus.request[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_wsel = bus.weight[int'(w_pick)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        w_wnew = (w_wsel == '0) ? ONE : w_wsel;
    end

    always_comb begin
        w_cur_req = bus.request[r_enc];
        w_cur_ack = bus.acknowledge[r_enc];
        w_release = r_valid &&
                    (!w_cur_req || (w_cur_ack && r_credit == ONE));
    end

    always_comb begin
        w_grant  = r_grant;
        w_enc    = r_enc;
        w_valid  = r_valid;
        w_credit = r_credit;
        w_last   = r_last;
        if (!r_valid || w_release) begin
            if (w_found) begin
                w_grant  = GBIT << w_pick;
                w_enc    = w_pick;
                w_valid  = 1'b1;
                w_credit = w_wnew;
                w_last   = w_pick;
            end else begin
                w_grant  = '0;
                w_enc    = '0;
                w_valid  = 1'b0;
                w_credit = '0;
            end
        end else if (w_cur_ack) begin
            // Held grant implies credit > 1 here, so no underflow.
            w_credit = r_credit - ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant  <= '0;
            r_enc    <= '0;
            r_valid  <= 1'b0;
            r_credit <= '0;
            r_last   <= LAST_RST;
        end else begin
            r_grant  <= w_grant;
            r_enc    <= w_enc;
            r_valid  <= w_valid;
            r_credit <= w_credit;
            r_last   <= w_last;
        end
    end

    assign bus.grant         = r_grant;
    assign bus.grant_encoded = r_enc;
    assign bus.grant_valid   = r_valid;
    assign bus.credit        = r_credit;

    a_credit_nz: assert property (
        @(posedge clk) disable iff (!rst_n)
        r_valid |-> (r_credit != '0));

    a_onehot: assert property (
        @(posedge clk) disable iff (!rst_n)
        $onehot0(r_grant) && (r_valid == (r_grant != '0)));
endmodule

// File: tb/tb_arbiter_wrr.sv
// Scoreboard bench for arbiter_wrr: one LSB-first and one
// MSB-first instance, expected grant/credit per cycle queued.
module tb_arbiter_wrr;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [10:0] q[$];

    arbiter_wrr_if #(.PORTS(4), .WEIGHT_WIDTH(4)) bus1 ();
    arbiter_wrr_if #(.PORTS(4), .WEIGHT_WIDTH(4)) bus0 ();

    arbiter_wrr #(
        .PORTS(4), .WEIGHT_WIDTH(4), .ARB_LSB_HIGH_PRIORITY(1)
    ) u_lsb1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    arbiter_wrr #(
        .PORTS(4), .WEIGHT_WIDTH(4), .ARB_LSB_HIGH_PRIORITY(0)
    ) u_lsb0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] ex(logic [3:0] g, logic [3:0] c);
        logic [1:0] e;
        e = 2'd0;
        for (int i = 0; i < 4; i++)
            if (g[i]) e = 2'(i);
        return {g, e, |g, c};
    endfunction

    function automatic logic [10:0] obs1();
        return {bus1.grant, bus1.grant_encoded,
                bus1.grant_valid, bus1.credit};
    endfunction

    function automatic logic [10:0] obs0();
        return {bus0.grant, bus0.grant_encoded,
                bus0.grant_valid, bus0.credit};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        bus1.request = '0;
        bus1.acknowledge = '0;
        bus0.request = '0;
        bus0.acknowledge = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [10:0] e;
        bus1.weight = 16'h1111;
        bus0.weight = 16'h1111;
        rst_n = 1'b0;
        bus1.request = 4'hF;
        bus0.request = 4'hF;
        bus1.acknowledge = '0;
        bus0.acknowledge = '0;
        #1;
        q.push_back(ex(4'b0000, 4'd0));
        q.push_back(ex(4'b0000, 4'd0));
        e = q.pop_front();
        checks++;
        if (obs1() !== e) begin
            errors++;
            $display("FAIL reset_lsb1: got %h required %h", obs1(), e);
        end
        e = q.pop_front();
        checks++;
        if (obs0() !== e) begin
            errors++;
            $display("FAIL reset_lsb0: got %h required %h", obs0(), e);
        end
        do_reset();
        @(posedge clk);
        #1;
        q.push_back(ex(4'b0000, 4'd0));
        e = q.pop_front();
        checks++;
        if (obs1() !== e) begin
            errors++;
            $display("FAIL reset_idle: got %h required %h", obs1(), e);
        end
    endtask

    task automatic test_rr();
        logic [10:0] e;
        do_reset();
        bus1.weight = 16'h1111;
        bus1.request = 4'hF;
        q.push_back(ex(4'b0000, 4'd0));
        for (int i = 0; i < 6; i++)
            q.push_back(ex(4'b0001 << (i % 4), 4'd1));
        for (int i = 0; i < 7; i++) begin
            e = q.pop_front();
            checks++;
            if (obs1() !== e) begin
                errors++;
                $display("FAIL rr step %0d: got %h required %h",
                         i, obs1(), e);
            end
            bus1.acknowledge = bus1.grant;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_weighted();
        logic [10:0] e;
        do_reset();
        bus1.weight = 16'h1213;
        bus1.request = 4'hF;
        q.push_back(ex(4'b0000, 4'd0));
        q.push_back(ex(4'b0001, 4'd3));
        q.push_back(ex(4'b0001, 4'd2));
        q.push_back(ex(4'b0001, 4'd1));
        q.push_back(ex(4'b0010, 4'd1));
        q.push_back(ex(4'b0100, 4'd2));
        q.push_back(ex(4'b0100, 4'd1));
        q.push_back(ex(4'b1000, 4'd1));
        q.push_back(ex(4'b0001, 4'd3));
        for (int i = 0; i < 9; i++) begin
            e = q.pop_front();
            checks++;
            if (obs1() !== e) begin
                errors++;
                $display("FAIL weighted step %0d: got %h required %h",
                         i, obs1(), e);
            end
            bus1.acknowledge = bus1.grant;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_weight_zero();
        logic [10:0] e;
        do_reset();
        bus1.weight = 16'h1101;
        bus1.request = 4'b0011;
        q.push_back(ex(4'b0000, 4'd0));
        for (int i = 0; i < 5; i++)
            q.push_back(ex(4'b0001 << (i % 2), 4'd1));
        for (int i = 0; i < 6; i++) begin
            e = q.pop_front();
            checks++;
            if (obs1() !== e) begin
                errors++;
                $display("FAIL weight0 step %0d: got %h required %h",
                         i, obs1(), e);
            end
            bus1.acknowledge = bus1.grant;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_early_release();
        logic [10:0] e;
        logic [3:0] req_s [6];
        logic [3:0] ack_s [6];
        req_s = '{4'b0001, 4'b0101, 4'b0101, 4'b0100, 4'b0101, 4'b0000};
        ack_s = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0101, 4'b0000};
        do_reset();
        bus1.weight = 16'h1615;
        q.push_back(ex(4'b0001, 4'd5));
        q.push_back(ex(4'b0001, 4'd4));
        q.push_back(ex(4'b0001, 4'd3));
        q.push_back(ex(4'b0100, 4'd6));
        q.push_back(ex(4'b0100, 4'd5));
        q.push_back(ex(4'b0000, 4'd0));
        for (int i = 0; i < 6; i++) begin
            bus1.request = req_s[i];
            bus1.acknowledge = ack_s[i];
            @(posedge clk);
            #1;
            e = q.pop_front();
            checks++;
            if (obs1() !== e) begin
                errors++;
                $display("FAIL early_rel step %0d: got %h required %h",
                         i, obs1(), e);
            end
        end
    endtask

    task automatic test_sole();
        logic [10:0] e;
        do_reset();
        bus1.weight = 16'h2111;
        bus1.request = 4'b1000;
        q.push_back(ex(4'b0000, 4'd0));
        for (int i = 0; i < 5; i++)
            q.push_back(ex(4'b1000, (i % 2 == 0) ? 4'd2 : 4'd1));
        q.push_back(ex(4'b0000, 4'd0));
        for (int i = 0; i < 7; i++) begin
            e = q.pop_front();
            checks++;
            if (obs1() !== e) begin
                errors++;
                $display("FAIL sole step %0d: got %h required %h",
                         i, obs1(), e);
            end
            if (i == 5) bus1.request = 4'b0000;
            bus1.acknowledge = bus1.grant;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] e;
        do_reset();
        bus0.weight = 16'h2131;
        bus0.request = 4'b0010;
        q.push_back(ex(4'b0010, 4'd3));
        q.push_back(ex(4'b0000, 4'd0));
        q.push_back(ex(4'b0000, 4'd0));
        q.push_back(ex(4'b1000, 4'd2));
        q.push_back(ex(4'b1000, 4'd1));
        q.push_back(ex(4'b0100, 4'd1));
        @(posedge clk);
        #1;
        e = q.pop_front();
        checks++;
        if (obs0() !== e) begin
            errors++;
            $display("FAIL rmid_grant: got %h required %h", obs0(), e);
        end
        #2;
        rst_n = 1'b0;
        #1;
        e = q.pop_front();
        checks++;
        if (obs0() !== e) begin
            errors++;
            $display("FAIL rmid_async: got %h required %h", obs0(), e);
        end
        bus0.request = 4'hF;
        @(posedge clk);
        #1;
        e = q.pop_front();
        checks++;
        if (obs0() !== e) begin
            errors++;
            $display("FAIL rmid_hold: got %h required %h", obs0(), e);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            e = q.pop_front();
            checks++;
            if (obs0() !== e) begin
                errors++;
                $display("FAIL rmid_after step %0d: got %h required %h",
                         i, obs0(), e);
            end
            bus0.acknowledge = bus0.grant;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rr();
        test_weighted();
        test_weight_zero();
        test_early_release();
        test_sole();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
